// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver constants, state enumeration and parity helper.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int SAMPLE_TICK = 8;
    localparam int TICK_W      = $clog2(OVERSAMPLE);

    typedef logic [TICK_W-1:0] tick_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Odd parity: the bit that makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, parity select and received-frame outputs of the UART receiver.
interface uart_rx_if;

    logic       rx;
    logic       parity_en;
    logic [7:0] dataout;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       idle;

    modport master (
        output rx, parity_en,
        input  dataout, rx_valid, parity_err, frame_err, idle
    );

    modport slave (
        input  rx, parity_en,
        output dataout, rx_valid, parity_err, frame_err, idle
    );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line plus falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // All three flops reset to the idle-high line level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver, 8 data bits, optional odd parity, one stop bit.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote over ticks 6, 7 and 8.
module uart_rx
    import uart_pkg::*;
(
    input  logic     baud_clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk    (baud_clk),
        .rst_n  (rst_n),
        .rx_i   (bus.rx),
        .rx_s_o (rx_s),
        .fall_o (rx_fall)
    );

    rx_state_e  state_q,   state_d;
    tick_t      tick_q,    tick_d;
    logic [2:0] idx_q,     idx_d;
    logic [7:0] shift_q,   shift_d;
    logic       par_en_q,  par_en_d;
    logic       par_bad_q, par_bad_d;
    logic [7:0] data_q,    data_d;
    logic       perr_q,    perr_d;
    logic       ferr_q,    ferr_d;
    logic       valid_q,   valid_d;

    logic decide;
    logic bit_val;

    assign decide = (tick_q == tick_t'(SAMPLE_TICK));

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early_q;

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            early_q <= 2'b11;
        end else if (state_q != IDLE) begin
            if (tick_q == tick_t'(SAMPLE_TICK - 2)) early_q[0] <= rx_s;
            if (tick_q == tick_t'(SAMPLE_TICK - 1)) early_q[1] <= rx_s;
        end
    end

    assign bit_val = (early_q[0] & early_q[1]) | (early_q[0] & rx_s) | (early_q[1] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q + tick_t'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bad_d = par_bad_q;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (rx_fall) begin
                    state_d   = START;
                    par_en_d  = bus.parity_en;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (decide) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_bad_d = (bit_val != odd_parity(shift_q));
                    state_d   = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop lets a start edge in the stop bit's second half be caught.
                if (decide) begin
                    data_d  = shift_q;
                    perr_d  = par_en_q & par_bad_q;
                    ferr_d  = ~bit_val;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dataout    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.idle       = (state_q == IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized frame stimulus against a frame-level scoreboard for uart_rx.
module tb_uart_rx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_if bus ();

    uart_rx dut (
        .baud_clk (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         cyc            = 0;
    int         checks         = 0;
    int         errors         = 0;
    int         nvalid         = 0;
    int         last_valid_cyc = -1;
    logic [7:0] last_data      = 8'h00;
    logic       last_perr      = 1'b0;
    logic       last_ferr      = 1'b0;
    logic [7:0] m_data         = 8'h00;
    logic       m_perr         = 1'b0;
    logic       m_ferr         = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Frame-level model: each frame must produce exactly one rx_valid at its predicted cycle,
    // and the outputs must not move between pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_dataout", 32'(bus.dataout), 32'h00);
            chk("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
            chk("reset_parity_err", 32'(bus.parity_err), 32'h0);
            chk("reset_frame_err", 32'(bus.frame_err), 32'h0);
            chk("reset_idle", 32'(bus.idle), 32'h1);
            m_data = 8'h00;
            m_perr = 1'b0;
            m_ferr = 1'b0;
        end else if (bus.rx_valid) begin
            nvalid++;
            last_valid_cyc = cyc;
            last_data      = bus.dataout;
            last_perr      = bus.parity_err;
            last_ferr      = bus.frame_err;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rx_valid: got pulse with data 0x%0h, expected none (cycle %0d)",
                         bus.dataout, cyc);
                m_data = bus.dataout;
                m_perr = bus.parity_err;
                m_ferr = bus.frame_err;
            end else begin
                cur = exp_q.pop_front();
                chk("valid_cycle", 32'(cyc), 32'(cur.cyc));
                chk("frame_data", 32'(bus.dataout), 32'(cur.data));
                chk("frame_parity_err", 32'(bus.parity_err), 32'(cur.perr));
                chk("frame_frame_err", 32'(bus.frame_err), 32'(cur.ferr));
                m_data = cur.data;
                m_perr = cur.perr;
                m_ferr = cur.ferr;
            end
        end else begin
            chk("hold_dataout", 32'(bus.dataout), 32'(m_data));
            chk("hold_parity_err", 32'(bus.parity_err), 32'(m_perr));
            chk("hold_frame_err", 32'(bus.frame_err), 32'(m_ferr));
            if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_rx_valid: got no pulse, expected one at cycle %0d (now %0d)",
                         exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1ns after a rising edge. A frame whose start bit is driven after edge ea is seen
    // by the receiver 3 edges later (two sync flops plus the edge-detect register), then rx_valid
    // follows 153 cycles later, or 169 with a parity bit.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stopv, input logic flip, output int ea);
        exp_t e;
        ea            = cyc;
        bus.rx        = 1'b0;
        bus.parity_en = pen;
        e.cyc  = ea + 3 + 153 + (pen ? 16 : 0);
        e.data = d;
        e.perr = pen ? (($countones({d, pbit}) % 2) == 0) : 1'b0;
        e.ferr = ~stopv;
        exp_q.push_back(e);
        hold(16);
        if (flip) bus.parity_en = ~pen;
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            hold(16);
        end
        if (pen) begin
            bus.rx = pbit;
            hold(16);
        end
        bus.rx = stopv;
        hold(16);
    endtask

    initial begin
        int         ea;
        int         n0;
        logic [7:0] d;
        logic       pen, pbit, stopv, flip;
        int         gap;

        bus.rx        = 1'b1;
        bus.parity_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(5);

        n0 = nvalid;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, ea);
        hold(20);
        chk("a5_latency", 32'(last_valid_cyc - ea), 32'd156);
        chk("a5_data", 32'(last_data), 32'hA5);
        chk("a5_parity_err", 32'(last_perr), 32'h0);
        chk("a5_frame_err", 32'(last_ferr), 32'h0);
        chk("a5_pulses", 32'(nvalid - n0), 32'd1);

        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, ea);
        hold(20);
        chk("p03_good_latency", 32'(last_valid_cyc - ea), 32'd172);
        chk("p03_good_data", 32'(last_data), 32'h03);
        chk("p03_good_parity_err", 32'(last_perr), 32'h0);

        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, ea);
        hold(20);
        chk("p03_bad_data", 32'(last_data), 32'h03);
        chk("p03_bad_parity_err", 32'(last_perr), 32'h1);

        n0     = nvalid;
        ea     = cyc;
        bus.rx = 1'b0;
        hold(4);
        bus.rx = 1'b1;
        @(negedge clk);
        chk("false_start_busy", 32'(bus.idle), 32'h0);
        repeat (8) @(negedge clk);
        chk("false_start_idle", 32'(bus.idle), 32'h1);
        @(posedge clk);
        #1;
        hold(20);
        chk("false_start_no_valid", 32'(nvalid - n0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, ea);
        hold(20);
        chk("after_false_start_data", 32'(last_data), 32'h5A);

        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, ea);
        bus.rx = 1'b1;
        hold(20);
        chk("stop_low_data", 32'(last_data), 32'hFF);
        chk("stop_low_frame_err", 32'(last_ferr), 32'h1);

        n0 = nvalid;
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, ea);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0, ea);
        hold(20);
        chk("b2b_pulses", 32'(nvalid - n0), 32'd2);
        chk("b2b_last_data", 32'(last_data), 32'h34);

        n0            = nvalid;
        bus.parity_en = 1'b0;
        bus.rx        = 1'b0;
        hold(16);
        for (int i = 0; i < 4; i++) begin
            bus.rx = (i % 2 == 0);
            hold(16);
        end
        bus.rx = 1'b0;
        hold(8);
        rst_n = 1'b0;
        hold(3);
        bus.rx = 1'b1;
        rst_n  = 1'b1;
        hold(30);
        chk("mid_reset_no_valid", 32'(nvalid - n0), 32'd0);
        chk("mid_reset_dataout", 32'(bus.dataout), 32'h00);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, ea);
        hold(20);
        chk("after_reset_data", 32'(last_data), 32'h81);

        for (int k = 0; k < 14; k++) begin
            d     = 8'($urandom);
            pen   = 1'($urandom_range(0, 1));
            pbit  = (($countones(d) % 2) == 0);
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            stopv = ($urandom_range(0, 4) != 0);
            flip  = 1'($urandom_range(0, 1));
            gap   = stopv ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
            send_frame(d, pen, pbit, stopv, flip, ea);
            bus.rx = 1'b1;
            hold(gap);
        end

        hold(200);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
